opponent_link_filter: RTL and testbench

//  Sits directly downstream of the Ethernet receive stage (eth_refclk domain, 50 MHz).
//  It consumes each 44-bit opponent frame (axiiv/axiid), field-checks it and holds the last good opponent state.
//  It also qualifies the remote reset bit and tracks link liveness.
//  Its registered outputs feed the eth->vga dual-port CDC buffer that supplies the game block.

---
 rtl/opponent_link_filter.sv | 133 +++++++++++++
 tb/tb_opponent_link_filter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/opponent_link_filter.sv
// Opponent frame filter for the Ethernet receive path. It field-checks each
// 44-bit frame, holds the last good opponent state, qualifies remote reset and tracks link liveness.
module opponent_link_filter #(
  parameter logic [10:0] TRACK_MAX      = 11'd1023,
  parameter logic [8:0]  DIR_MAX        = 9'd359,
  parameter int unsigned TIMEOUT_CYCLES = 5_000_000,
  parameter int unsigned RST_CONFIRM    = 3
) (
  input  logic        clk_in,
  input  logic        rst_in_n,
  input  logic        axiiv,
  input  logic [43:0] axiid,
  output logic [10:0] opp_x,
  output logic [10:0] opp_y,
  output logic [8:0]  opp_dir,
  output logic [2:0]  opp_game,
  output logic        opp_upd,
  output logic        opp_rst,
  output logic        link_up,
  output logic [7:0]  err_count
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RW = $clog2(RST_CONFIRM + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RUN_MAX = RW'(RST_CONFIRM);

  typedef struct packed {
    logic [10:0] x;
    logic        p32;
    logic [10:0] y;
    logic        p20;
    logic [8:0]  dir;
    logic [2:0]  p10_8;
    logic [2:0]  game;
    logic        p4;
    logic        rst;
    logic [2:0]  p2_0;
  } frame_t;

  typedef enum logic [1:0] {DOWN, UP, STALE} state_t;

  frame_t          f;
  state_t          state, state_nxt;
  logic [TW-1:0]   to_cnt, to_cnt_nxt;
  logic [RW-1:0]   run_cnt, run_cnt_nxt;
  logic            rst_armed, rst_armed_nxt;
  logic            frame_ok, f_valid, f_bad, fire, differs;

  assign f = frame_t'(axiid);

  assign frame_ok = !f.p32 && !f.p20 && (f.p10_8 == 3'd0) && !f.p4 && (f.p2_0 == 3'd0)
                 && (f.x <= TRACK_MAX) && (f.y <= TRACK_MAX) && (f.dir <= DIR_MAX);
  assign f_valid  = axiiv && frame_ok;
  assign f_bad    = axiiv && !frame_ok;
  assign differs  = (f.x != opp_x) || (f.y != opp_y) || (f.dir != opp_dir) || (f.game != opp_game);
  assign link_up  = (state == UP);

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) state <= DOWN;
    else           state <= state_nxt;
  end

  // Any cycle without a valid frame ages the link while UP; a valid frame always wins over expiry.
  always_comb begin
    state_nxt  = state;
    to_cnt_nxt = to_cnt;
    case (state)
      DOWN: if (f_valid) state_nxt = UP;
      UP: begin
        if (f_valid) begin
          to_cnt_nxt = '0;
        end else if (to_cnt == TO_LAST) begin
          state_nxt  = STALE;
          to_cnt_nxt = '0;
        end else begin
          to_cnt_nxt = to_cnt + 1'b1;
        end
      end
      STALE: if (f_valid) state_nxt = UP;
      default: state_nxt = DOWN;
    endcase
    if (f_valid) to_cnt_nxt = '0;
  end

  // Remote reset fires once per run of RST_CONFIRM reset-flagged frames; a clear frame re-arms.
  always_comb begin
    run_cnt_nxt   = run_cnt;
    rst_armed_nxt = rst_armed;
    fire          = 1'b0;
    if (f_valid) begin
      if (f.rst) begin
        if (run_cnt != RUN_MAX) run_cnt_nxt = run_cnt + 1'b1;
        if (run_cnt_nxt == RUN_MAX && rst_armed) begin
          fire          = 1'b1;
          rst_armed_nxt = 1'b0;
        end
      end else begin
        run_cnt_nxt   = '0;
        rst_armed_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      to_cnt    <= '0;
      run_cnt   <= '0;
      rst_armed <= 1'b1;
      opp_x     <= '0;
      opp_y     <= '0;
      opp_dir   <= '0;
      opp_game  <= '0;
      opp_upd   <= 1'b0;
      opp_rst   <= 1'b0;
      err_count <= '0;
    end else begin
      to_cnt    <= to_cnt_nxt;
      run_cnt   <= run_cnt_nxt;
      rst_armed <= rst_armed_nxt;
      opp_upd   <= f_valid && differs;
      opp_rst   <= fire;
      if (f_valid) begin
        opp_x    <= f.x;
        opp_y    <= f.y;
        opp_dir  <= f.dir;
        opp_game <= f.game;
      end
      if (f_bad && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_opponent_link_filter.sv
// Directed bench for opponent_link_filter with a short link timeout.
module tb_opponent_link_filter;

  logic        clk_in = 1'b0;
  logic        rst_in_n;
  logic        axiiv;
  logic [43:0] axiid;
  logic [10:0] opp_x, opp_y;
  logic [8:0]  opp_dir;
  logic [2:0]  opp_game;
  logic        opp_upd, opp_rst, link_up;
  logic [7:0]  err_count;

  int passed = 0;
  int total  = 0;

  opponent_link_filter #(
    .TIMEOUT_CYCLES(16),
    .RST_CONFIRM(3)
  ) dut (
    .clk_in(clk_in), .rst_in_n(rst_in_n), .axiiv(axiiv), .axiid(axiid),
    .opp_x(opp_x), .opp_y(opp_y), .opp_dir(opp_dir), .opp_game(opp_game),
    .opp_upd(opp_upd), .opp_rst(opp_rst), .link_up(link_up), .err_count(err_count)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [43:0] mk(input int x, input int y, input int d, input int g, input bit r);
    logic [10:0] xx, yy;
    logic [8:0]  dd;
    logic [2:0]  gg;
    xx = 11'(x); yy = 11'(y); dd = 9'(d); gg = 3'(g);
    return {xx, 1'b0, yy, 1'b0, dd, 3'b000, gg, 1'b0, r, 3'b000};
  endfunction

  // Present one frame for a single cycle; returns at posedge+1 with the result registered.
  task automatic send(input logic [43:0] fr);
    axiiv = 1'b1; axiid = fr;
    @(posedge clk_in); #1;
    axiiv = 1'b0; axiid = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk_in); #1; end
  endtask

  task automatic test_reset;
    rst_in_n = 1'b1; axiiv = 1'b0; axiid = '0;
    #3 rst_in_n = 1'b0;
    #1;
    total++; if ({opp_x, opp_y, opp_dir, opp_game, opp_upd, opp_rst, err_count} !== '0)
      $display("FAIL reset_outputs got %h exp 0", {opp_x, opp_y, opp_dir, opp_game, opp_upd, opp_rst, err_count}); else passed++;
    total++; if (link_up !== 1'b0) $display("FAIL reset_link got %b exp 0", link_up); else passed++;
    idle(2);
    rst_in_n = 1'b1;
    idle(1);
  endtask

  task automatic test_first_frame;
    send(mk(191, 191, 270, 1, 0));
    total++; if (opp_x !== 11'd191) $display("FAIL t1_x got %0d exp 191", opp_x); else passed++;
    total++; if (opp_y !== 11'd191) $display("FAIL t1_y got %0d exp 191", opp_y); else passed++;
    total++; if (opp_dir !== 9'd270) $display("FAIL t1_dir got %0d exp 270", opp_dir); else passed++;
    total++; if (opp_game !== 3'd1) $display("FAIL t1_game got %0d exp 1", opp_game); else passed++;
    total++; if (opp_upd !== 1'b1) $display("FAIL t1_upd got %b exp 1", opp_upd); else passed++;
    total++; if (link_up !== 1'b1) $display("FAIL t1_link got %b exp 1", link_up); else passed++;
    idle(1);
    total++; if (opp_upd !== 1'b0) $display("FAIL t1_upd_pulse got %b exp 0", opp_upd); else passed++;
  endtask

  task automatic test_identical_and_bad_dir;
    send(mk(191, 191, 270, 1, 0));
    total++; if (opp_upd !== 1'b0) $display("FAIL t2_same_upd got %b exp 0", opp_upd); else passed++;
    idle(14);
    total++; if (link_up !== 1'b1) $display("FAIL t2_timeout_cleared got %b exp 1", link_up); else passed++;
    send(mk(191, 191, 360, 1, 0));
    total++; if (err_count !== 8'd1) $display("FAIL t2_err got %0d exp 1", err_count); else passed++;
    total++; if (opp_dir !== 9'd270) $display("FAIL t2_dir_held got %0d exp 270", opp_dir); else passed++;
    total++; if (opp_upd !== 1'b0) $display("FAIL t2_bad_upd got %b exp 0", opp_upd); else passed++;
  endtask

  task automatic test_pad_and_saturation;
    logic [43:0] fr;
    fr = mk(100, 100, 10, 2, 0);
    fr[32] = 1'b1;
    send(fr);
    total++; if (err_count !== 8'd2) $display("FAIL t3_pad_err got %0d exp 2", err_count); else passed++;
    total++; if (opp_x !== 11'd191) $display("FAIL t3_pad_x got %0d exp 191", opp_x); else passed++;
    axiiv = 1'b1; axiid = mk(1024, 0, 0, 0, 0);
    repeat (256) @(posedge clk_in);
    #1 axiiv = 1'b0;
    total++; if (err_count !== 8'd255) $display("FAIL t3_sat got %0d exp 255", err_count); else passed++;
    send(mk(0, 2000, 0, 0, 0));
    total++; if (err_count !== 8'd255) $display("FAIL t3_sat_hold got %0d exp 255", err_count); else passed++;
  endtask

  task automatic test_remote_reset;
    bit exp_r [8] = '{0, 0, 1, 0, 0, 0, 0, 1};
    bit bits  [8] = '{1, 1, 1, 1, 0, 1, 1, 1};
    for (int i = 0; i < 8; i++) begin
      send(mk(10, 20, 30, 2, bits[i]));
      total++; if (opp_rst !== exp_r[i]) $display("FAIL t4_rst_%0d got %b exp %b", i, opp_rst, exp_r[i]); else passed++;
      if (i == 0) begin
        total++; if (link_up !== 1'b1) $display("FAIL t4_stale_to_up got %b exp 1", link_up); else passed++;
      end
    end
  endtask

  task automatic test_timeout;
    send(mk(5, 6, 7, 3, 0));
    idle(15);
    total++; if (link_up !== 1'b1) $display("FAIL t5_before_expiry got %b exp 1", link_up); else passed++;
    idle(1);
    total++; if (link_up !== 1'b0) $display("FAIL t5_stale got %b exp 0", link_up); else passed++;
    total++; if ({opp_x, opp_y, opp_dir, opp_game} !== {11'd5, 11'd6, 9'd7, 3'd3})
      $display("FAIL t5_held got %0d/%0d/%0d/%0d exp 5/6/7/3", opp_x, opp_y, opp_dir, opp_game); else passed++;
    send(mk(5, 6, 7, 3, 0));
    total++; if (link_up !== 1'b1) $display("FAIL t5_relink got %b exp 1", link_up); else passed++;
  endtask

  task automatic test_expiry_race;
    idle(15);
    send(mk(8, 9, 10, 4, 0));
    total++; if (link_up !== 1'b1) $display("FAIL t6_race_up got %b exp 1", link_up); else passed++;
    idle(15);
    total++; if (link_up !== 1'b1) $display("FAIL t6_race_cleared got %b exp 1", link_up); else passed++;
  endtask

  task automatic test_back_to_back;
    int xs [3] = '{300, 301, 1023};
    axiiv = 1'b1;
    for (int i = 0; i < 3; i++) begin
      axiid = mk(xs[i], 40, 359, 5, 0);
      @(posedge clk_in); #1;
      total++; if (opp_x !== 11'(xs[i])) $display("FAIL b2b_x_%0d got %0d exp %0d", i, opp_x, xs[i]); else passed++;
      total++; if (opp_upd !== 1'b1) $display("FAIL b2b_upd_%0d got %b exp 1", i, opp_upd); else passed++;
    end
    axiiv = 1'b0;
  endtask

  task automatic test_reset_mid_frame;
    axiiv = 1'b1; axiid = mk(77, 88, 99, 6, 0);
    #2 rst_in_n = 1'b0;
    #1;
    total++; if ({opp_x, opp_y, opp_dir, opp_game, opp_upd, opp_rst, err_count, link_up} !== '0)
      $display("FAIL t6_async_reset got %h exp 0", {opp_x, opp_y, opp_dir, opp_game, opp_upd, opp_rst, err_count, link_up}); else passed++;
    @(posedge clk_in); #1;
    axiiv = 1'b0; rst_in_n = 1'b1;
    idle(1);
    total++; if (opp_x !== 11'd0 || link_up !== 1'b0) $display("FAIL t6_discard got x=%0d link=%b exp 0/0", opp_x, link_up); else passed++;
    send(mk(3, 4, 5, 1, 0));
    total++; if (link_up !== 1'b1 || opp_x !== 11'd3) $display("FAIL t6_down_to_up got link=%b x=%0d exp 1/3", link_up, opp_x); else passed++;
  endtask

  initial begin
    test_reset;
    test_first_frame;
    test_identical_and_bad_dir;
    test_pad_and_saturation;
    test_remote_reset;
    test_timeout;
    test_expiry_race;
    test_back_to_back;
    test_reset_mid_frame;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
